// File: rtl/test_wrapper_pkg.sv
// Shared constants and types for the test_wrapper stream-to-memory slice.
package test_wrapper_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 12;

   localparam logic [REG_AW-1:0] REG_DMA_EN     = 12'h000;
   localparam logic [REG_AW-1:0] REG_DMA_BASE   = 12'h010;
   localparam logic [REG_AW-1:0] REG_DMA_LEN    = 12'h014;
   localparam logic [REG_AW-1:0] REG_DMA_CYCLES = 12'h018;
   localparam logic [REG_AW-1:0] REG_DMA_START  = 12'h020;
   localparam logic [REG_AW-1:0] REG_AL_EN      = 12'h100;
   localparam logic [REG_AW-1:0] REG_AL_MAXCNT  = 12'h10C;
   localparam logic [REG_AW-1:0] REG_AL_CNTPASS = 12'h110;
   localparam logic [REG_AW-1:0] REG_SKID_EN    = 12'h200;
   localparam logic [REG_AW-1:0] REG_MUX_SEL    = 12'h300;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dma_state_e;

endpackage

// File: rtl/test_wrapper_skid_fifo.sv
// Small FIFO between aligner and DMA; both ready and valid come straight from flops.
module skid_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data_c,
   input  logic             out_ready
);
   import test_wrapper_pkg::*;

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_c, pop_c;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy next-state; a disabled FIFO collapses to empty
   always_comb begin
      push_c  = en && in_valid && in_ready;
      pop_c   = en && out_valid && out_ready;
      count_d = count_q;
      if (!en)                 count_d = '0;
      else if (push_c && !pop_c) count_d = count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         count_q   <= count_d;
         in_ready  <= !en || (count_d < CNT_W'(DEPTH));
         out_valid <= (count_d != '0);
         if (!en) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_c) begin
               mem_q[wr_ptr_q] <= in_data;
               wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_c) rd_ptr_q <= next_ptr(rd_ptr_q);
         end
      end
   end

   assign out_data_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/test_wrapper.sv
// Register-configured stream path: aligner -> skid FIFO -> DMA memory writer, with a monitor tap.
module test_wrapper #(
   parameter int unsigned DATA_W     = test_wrapper_pkg::DATA_W,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                                clk,
   input  logic                                areset,
   input  logic                                reg_wr,
   input  logic                                reg_rd,
   input  logic [test_wrapper_pkg::REG_AW-1:0] reg_addr,
   input  logic [31:0]                         reg_wdata,
   output logic [31:0]                         reg_rdata,
   input  logic                                s_valid,
   input  logic [DATA_W-1:0]                   s_data,
   output logic                                s_ready,
   output logic                                m_valid,
   output logic [31:0]                         m_addr,
   output logic [DATA_W-1:0]                   m_data,
   input  logic                                m_ready,
   output logic                                o_valid,
   output logic [DATA_W-1:0]                   o_data,
   output logic                                o_last
);
   import test_wrapper_pkg::*;

   logic        dma_en_q, al_en_q, al_cntpass_q, skid_en_q, mux_sel_q, rst_done_q;
   logic [31:0] dma_base_q, dma_len_q, dma_cycles_q, al_maxcnt_q, al_cnt_q;
   logic [31:0] rd_val_c;
   logic        start_c;

   dma_state_e        state_q, state_d;
   logic [31:0]       rem_q, rem_d, addr_q, addr_d, widx_q, widx_d, m_addr_d;
   logic              m_valid_d, hs_c, dma_take_c;
   logic [DATA_W-1:0] m_data_d;

   logic              al_fire_c, al_last_c;
   logic [DATA_W-1:0] al_data_c;
   logic              fifo_in_ready, fifo_out_valid;
   logic [DATA_W-1:0] fifo_out_data;

   assign start_c = reg_wr && (reg_addr == REG_DMA_START) && dma_en_q;

   always_comb begin
      rd_val_c = '0;
      case (reg_addr)
         REG_DMA_EN:     rd_val_c = {31'd0, dma_en_q};
         REG_DMA_BASE:   rd_val_c = dma_base_q;
         REG_DMA_LEN:    rd_val_c = dma_len_q;
         REG_DMA_CYCLES: rd_val_c = dma_cycles_q;
         REG_DMA_START:  rd_val_c = rem_q;
         REG_AL_EN:      rd_val_c = {31'd0, al_en_q};
         REG_AL_MAXCNT:  rd_val_c = al_maxcnt_q;
         REG_AL_CNTPASS: rd_val_c = {31'd0, al_cntpass_q};
         REG_SKID_EN:    rd_val_c = {31'd0, skid_en_q};
         REG_MUX_SEL:    rd_val_c = {31'd0, mux_sel_q};
         default:        rd_val_c = '0;
      endcase
   end

   // Configuration registers and registered read data
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         dma_en_q     <= 1'b0;
         dma_base_q   <= '0;
         dma_len_q    <= '0;
         dma_cycles_q <= '0;
         al_en_q      <= 1'b0;
         al_maxcnt_q  <= '0;
         al_cntpass_q <= 1'b0;
         skid_en_q    <= 1'b0;
         mux_sel_q    <= 1'b0;
         reg_rdata    <= '0;
         rst_done_q   <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
         if (reg_wr) begin
            case (reg_addr)
               REG_DMA_EN:     dma_en_q     <= reg_wdata[0];
               REG_DMA_BASE:   dma_base_q   <= reg_wdata;
               REG_DMA_LEN:    dma_len_q    <= reg_wdata;
               REG_DMA_CYCLES: dma_cycles_q <= reg_wdata;
               REG_AL_EN:      al_en_q      <= reg_wdata[0];
               REG_AL_MAXCNT:  al_maxcnt_q  <= reg_wdata;
               REG_AL_CNTPASS: al_cntpass_q <= reg_wdata[0];
               REG_SKID_EN:    skid_en_q    <= reg_wdata[0];
               REG_MUX_SEL:    mux_sel_q    <= reg_wdata[0];
               default: ;
            endcase
         end
         if (reg_rd) reg_rdata <= rd_val_c;
      end
   end

   // Aligner: a disabled aligner sinks everything; otherwise ready comes from the FIFO
   assign s_ready   = rst_done_q && (!al_en_q || fifo_in_ready);
   assign al_fire_c = al_en_q && s_valid && s_ready;
   assign al_last_c = (al_maxcnt_q != '0) && (al_cnt_q == al_maxcnt_q);
   assign al_data_c = al_cntpass_q ? DATA_W'(al_cnt_q) : s_data;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         al_cnt_q <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_last   <= 1'b0;
      end else begin
         if (al_fire_c) al_cnt_q <= al_last_c ? '0 : al_cnt_q + 32'd1;
         o_valid <= mux_sel_q && al_fire_c;
         o_last  <= mux_sel_q && al_fire_c && al_last_c;
         o_data  <= al_data_c;
      end
   end

   skid_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk        (clk),
      .areset     (areset),
      .en         (skid_en_q),
      .in_valid   (s_valid && al_en_q),
      .in_data    (al_data_c),
      .in_ready   (fifo_in_ready),
      .out_valid  (fifo_out_valid),
      .out_data_c (fifo_out_data),
      .out_ready  (dma_take_c)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         addr_q  <= '0;
         widx_q  <= '0;
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         widx_q  <= widx_d;
         m_valid <= m_valid_d;
         m_addr  <= m_addr_d;
         m_data  <= m_data_d;
      end
   end

   // DMA: one word in flight; later branches (abort, start) take priority
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      addr_d     = addr_q;
      widx_d     = widx_q;
      m_valid_d  = m_valid;
      m_addr_d   = m_addr;
      m_data_d   = m_data;
      hs_c       = m_valid && m_ready;
      dma_take_c = (state_q == DONE) || ((state_q == BUSY) && !m_valid);

      if (hs_c) begin
         m_valid_d = 1'b0;
         rem_d     = rem_q - 32'd1;
         if (widx_q == dma_len_q) begin
            widx_d = '0;
            addr_d = dma_base_q;
         end else begin
            widx_d = widx_q + 32'd1;
            addr_d = addr_q + 32'd4;
         end
         if (rem_q == 32'd1) state_d = DONE;
      end

      if ((state_q == BUSY) && !m_valid && fifo_out_valid) begin
         m_valid_d = 1'b1;
         m_addr_d  = addr_q;
         m_data_d  = fifo_out_data;
      end

      if (!dma_en_q && (state_q == BUSY)) begin
         state_d   = DONE;
         rem_d     = '0;
         m_valid_d = 1'b0;
      end

      if (start_c) begin
         state_d = BUSY;
         rem_d   = 32'((dma_len_q + 32'd1) * (dma_cycles_q + 32'd1));
         addr_d  = dma_base_q;
         widx_d  = '0;
      end
   end

endmodule

// File: tb/tb_test_wrapper.sv
// Scoreboard bench for test_wrapper: memory writes and monitor beats checked against a reference model.
module tb_test_wrapper;

   logic        clk = 1'b0;
   logic        areset;
   logic        reg_wr, reg_rd;
   logic [11:0] reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_data;
   logic        m_valid, m_ready;
   logic [31:0] m_addr, m_data;
   logic        o_valid, o_last;
   logic [31:0] o_data;

   test_wrapper #(.DATA_W(32), .SKID_DEPTH(2)) dut (
      .clk(clk), .areset(areset),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } mem_exp_t;
   typedef struct packed { logic last; logic [31:0] data; } mon_exp_t;

   mem_exp_t mem_q[$];
   mon_exp_t mon_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // reference model of the configuration
   logic [31:0] cfg_base, cfg_len, cfg_cycles, cfg_maxcnt, al_cnt_m;
   bit          cfg_dma_en, cfg_al_en, cfg_cntpass, cfg_mux, cfg_skid, dma_live;
   int          dma_words, dma_total;

   // stimulus driven at the next negedge
   logic        g_sv, g_wr, g_rd, mr_val;
   logic [31:0] g_sd, g_wdata;
   logic [11:0] g_addr;
   bit          bp_en, stab_en, prev_stall, acc;
   logic [31:0] prev_addr, prev_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      mem_exp_t me;
      mon_exp_t oe;
      @(negedge clk);
      s_valid   = g_sv;
      s_data    = g_sd;
      reg_wr    = g_wr;
      reg_rd    = g_rd;
      reg_addr  = g_addr;
      reg_wdata = g_wdata;
      m_ready   = bp_en ? 1'($urandom_range(0, 1)) : mr_val;
      #1;
      if (o_valid) begin
         if (mon_q.size() == 0) chk("o_extra", 32'(o_valid), 32'd0);
         else begin
            oe = mon_q.pop_front();
            chk("o_data", o_data, oe.data);
            chk("o_last", 32'(o_last), 32'(oe.last));
         end
      end
      if (stab_en && prev_stall) begin
         chk("stall_valid", 32'(m_valid), 32'd1);
         chk("stall_addr", m_addr, prev_addr);
         chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
         if (mem_q.size() == 0) chk("m_extra", 32'(m_valid), 32'd0);
         else begin
            me = mem_q.pop_front();
            chk("m_addr", m_addr, me.addr);
            chk("m_data", m_data, me.data);
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_addr  = m_addr;
      prev_data  = m_data;
      acc = s_valid && s_ready;
      if (acc && cfg_al_en) begin
         oe.data  = cfg_cntpass ? al_cnt_m : s_data;
         oe.last  = (cfg_maxcnt != 0) && (al_cnt_m == cfg_maxcnt);
         al_cnt_m = oe.last ? 32'd0 : al_cnt_m + 32'd1;
         if (cfg_mux) mon_q.push_back(oe);
         if (cfg_skid && dma_live && dma_words < dma_total) begin
            me.addr = cfg_base + 32'(4 * (dma_words % (int'(cfg_len) + 1)));
            me.data = oe.data;
            mem_q.push_back(me);
            dma_words++;
         end
      end
      g_wr = 1'b0;
      g_rd = 1'b0;
   endtask

   task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
      g_wr = 1'b1; g_addr = a; g_wdata = d;
      cycle();
      case (a)
         12'h000: begin cfg_dma_en = d[0]; if (!d[0]) dma_live = 0; end
         12'h010: cfg_base   = d;
         12'h014: cfg_len    = d;
         12'h018: cfg_cycles = d;
         12'h020: if (cfg_dma_en) begin
                     dma_live  = 1;
                     dma_words = 0;
                     dma_total = (int'(cfg_len) + 1) * (int'(cfg_cycles) + 1);
                  end
         12'h100: cfg_al_en   = d[0];
         12'h10C: cfg_maxcnt  = d;
         12'h110: cfg_cntpass = d[0];
         12'h200: cfg_skid    = d[0];
         12'h300: cfg_mux     = d[0];
         default: ;
      endcase
   endtask

   task automatic reg_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
      g_rd = 1'b1; g_addr = a;
      cycle();
      cycle();
      chk(tag, reg_rdata, exp);
   endtask

   task automatic feed(input int n, input bit rnd, output int n_acc);
      n_acc = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         g_sv = 1'b1;
         g_sd = rnd ? $urandom : 32'(i);
         do begin
            cycle();
            w++;
         end while (!acc && w < 200);
         if (!acc) begin
            chk("feed_timeout", 32'(acc), 32'd1);
            break;
         end
         n_acc++;
      end
      g_sv = 1'b0;
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      while ((mem_q.size() != 0 || mon_q.size() != 0) && w < 600) begin
         cycle();
         w++;
      end
      repeat (8) cycle();
      chk(tag, 32'(mem_q.size() + mon_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_rdata", reg_rdata, 32'd0);
      mem_q.delete();
      mon_q.delete();
      {cfg_base, cfg_len, cfg_cycles, cfg_maxcnt, al_cnt_m} = '0;
      {cfg_dma_en, cfg_al_en, cfg_cntpass, cfg_mux, cfg_skid, dma_live} = '0;
      dma_words = 0; dma_total = 0;
      {g_sv, g_wr, g_rd} = '0;
      g_sd = '0; g_wdata = '0; g_addr = '0;
      bp_en = 0; stab_en = 0; prev_stall = 0; mr_val = 1'b1;
      repeat (2) cycle();
      areset = 1'b0;
      cycle();
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
   endtask

   task automatic setup_dma(input logic [31:0] base, input logic [31:0] len, input logic [31:0] cyc);
      reg_write(12'h000, 32'd1);
      reg_write(12'h010, base);
      reg_write(12'h014, len);
      reg_write(12'h018, cyc);
      reg_write(12'h100, 32'd1);
      reg_write(12'h10C, 32'h20);
      reg_write(12'h200, 32'd1);
      reg_write(12'h020, 32'd1);
   endtask

   initial begin
      int cnt;
      {reg_wr, reg_rd, s_valid, m_ready} = '0;
      reg_addr = '0; reg_wdata = '0; s_data = '0;
      do_reset();

      // default transfer: 11 words at 0x00..0x28, the rest discarded
      setup_dma(32'h0, 32'd10, 32'd0);
      feed(32, 0, cnt);
      chk("t1_accepted", 32'(cnt), 32'd32);
      drain("t1_left");
      reg_read(12'h020, 32'd0, "t1_remaining");
      reg_read(12'h014, 32'd10, "t1_len_rb");
      reg_write(12'h008, 32'hDEAD_BEEF);
      reg_read(12'h008, 32'd0, "t1_unmapped");

      // repeat: two passes over 0x100..0x10C
      do_reset();
      setup_dma(32'h100, 32'd3, 32'd1);
      feed(8, 0, cnt);
      drain("t2_left");
      reg_read(12'h020, 32'd0, "t2_remaining");

      // random m_ready with hold checks
      do_reset();
      bp_en = 1; stab_en = 1;
      setup_dma(32'h40, 32'd7, 32'd1);
      feed(20, 1, cnt);
      chk("t3_accepted", 32'(cnt), 32'd20);
      drain("t3_left");
      reg_read(12'h020, 32'd0, "t3_remaining");
      bp_en = 0; stab_en = 0;

      // aligner framing and counter passthrough on the monitor
      do_reset();
      reg_write(12'h100, 32'd1);
      reg_write(12'h10C, 32'd3);
      reg_write(12'h300, 32'd1);
      feed(12, 1, cnt);
      reg_write(12'h110, 32'd1);
      feed(8, 1, cnt);
      reg_write(12'h10C, 32'd0);
      feed(6, 1, cnt);
      reg_write(12'h100, 32'd0);
      feed(3, 1, cnt);
      chk("t4_drop_accepted", 32'(cnt), 32'd3);
      drain("t4_left");

      // abort mid-transfer
      do_reset();
      setup_dma(32'h0, 32'd15, 32'd0);
      feed(5, 1, cnt);
      drain("t5_pre_left");
      reg_read(12'h020, 32'd11, "t5_remaining_mid");
      reg_write(12'h000, 32'd0);
      feed(6, 1, cnt);
      chk("t5_discard_accepted", 32'(cnt), 32'd6);
      drain("t5_left");
      chk("t5_m_valid", 32'(m_valid), 32'd0);
      reg_read(12'h020, 32'd0, "t5_remaining");

      // reset mid-transfer with a word held on the memory port
      do_reset();
      setup_dma(32'h80, 32'd15, 32'd0);
      mr_val = 1'b0;
      feed(3, 1, cnt);
      cycle();
      chk("t6_pre_m_valid", 32'(m_valid), 32'd1);
      reg_read(12'h010, 32'h80, "t6_base_rb");
      @(posedge clk);
      #2;
      do_reset();
      reg_read(12'h000, 32'd0, "t6_dma_en");
      reg_read(12'h010, 32'd0, "t6_base");
      reg_read(12'h020, 32'd0, "t6_remaining");
      reg_read(12'h10C, 32'd0, "t6_maxcnt");
      drain("t6_left");
      chk("t6_m_valid", 32'(m_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
